// File: rtl/lsu_axi_master.sv
// AXI-Lite master bridge: turns one outstanding LSU request into an AR/R or AW/W/B
// transaction and returns a single-cycle completion pulse.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              axi_aw_valid,
  input  logic              axi_aw_ready,
  output logic [ADDR_W-1:0] axi_aw_addr,
  output logic              axi_w_valid,
  input  logic              axi_w_ready,
  output logic [DATA_W-1:0] axi_w_data,
  output logic [STRB_W-1:0] axi_w_strb,
  input  logic              axi_b_valid,
  output logic              axi_b_ready,
  input  logic [1:0]        axi_b_resp,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic [1:0]        axi_r_resp
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                ar_valid_q, ar_valid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                aw_fire, w_fire;

  assign aw_fire = aw_valid_q && axi_aw_ready;
  assign w_fire  = w_valid_q && axi_w_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_valid_d   = aw_valid_q;
    w_valid_d    = w_valid_q;
    ar_valid_d   = ar_valid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_wen) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = WADDR;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W retire independently; leave as soon as both have completed.
        if (aw_fire) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_fire) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (axi_b_valid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = (axi_b_resp != 2'b00);
          resp_rdata_d = '0;
          state_d      = IDLE;
        end
      end
      RADDR: begin
        if (ar_valid_q && axi_ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = RDATA;
        end
      end
      RDATA: begin
        if (axi_r_valid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = (axi_r_resp != 2'b00);
          resp_rdata_d = axi_r_data;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      ar_valid_q   <= ar_valid_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Response readies follow the state, so stray responses elsewhere are never taken.
  assign req_ready    = (state_q == IDLE);
  assign axi_b_ready  = (state_q == WRESP);
  assign axi_r_ready  = (state_q == RDATA);
  assign axi_aw_valid = aw_valid_q;
  assign axi_aw_addr  = addr_q;
  assign axi_w_valid  = w_valid_q;
  assign axi_w_data   = wdata_q;
  assign axi_w_strb   = wstrb_q;
  assign axi_ar_valid = ar_valid_q;
  assign axi_ar_addr  = addr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master against a small AXI-Lite SRAM slave model
// with controllable ready, error and response-stall behaviour.
module tb_lsu_axi_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        axi_aw_valid, axi_aw_ready;
  logic [31:0] axi_aw_addr;
  logic        axi_w_valid, axi_w_ready;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid, axi_b_ready;
  logic [1:0]  axi_b_resp;
  logic        axi_ar_valid, axi_ar_ready;
  logic [31:0] axi_ar_addr;
  logic        axi_r_valid, axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int overlap = 0;

  logic slave_rst, err_mode, b_stall;

  always #5 clock = ~clock;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp)
  );

  // SRAM slave model: B/R are raised on the edge of the completing handshake.
  logic [63:0] mem [0:255];
  logic        aw_got, w_got;
  logic [31:0] aw_addr_s;
  logic [63:0] w_data_s;
  logic [7:0]  w_strb_s;
  logic        aw_hs, w_hs, aw_have, w_have;
  logic [31:0] wa;
  logic [63:0] wd;
  logic [7:0]  ws;

  assign aw_hs   = axi_aw_valid && axi_aw_ready;
  assign w_hs    = axi_w_valid && axi_w_ready;
  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got || w_hs;
  assign wa      = aw_got ? aw_addr_s : axi_aw_addr;
  assign wd      = w_got ? w_data_s : axi_w_data;
  assign ws      = w_got ? w_strb_s : axi_w_strb;

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (slave_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
      aw_got <= 1'b0; w_got <= 1'b0;
      axi_b_valid <= 1'b0; axi_b_resp <= 2'b00;
      axi_r_valid <= 1'b0; axi_r_resp <= 2'b00; axi_r_data <= 64'd0;
    end else begin
      if (axi_b_valid && axi_b_ready) axi_b_valid <= 1'b0;
      if (aw_have && w_have && !b_stall && !axi_b_valid) begin
        mem[wa[10:3]] <= merge(mem[wa[10:3]], wd, ws);
        axi_b_valid   <= 1'b1;
        axi_b_resp    <= err_mode ? 2'b10 : 2'b00;
        aw_got        <= 1'b0;
        w_got         <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= axi_aw_addr; end
        if (w_hs) begin w_got <= 1'b1; w_data_s <= axi_w_data; w_strb_s <= axi_w_strb; end
      end
      if (axi_ar_valid && axi_ar_ready) begin
        axi_r_valid <= 1'b1;
        axi_r_data  <= err_mode ? 64'hDEAD : mem[axi_ar_addr[10:3]];
        axi_r_resp  <= err_mode ? 2'b10 : 2'b00;
      end else if (axi_r_valid && axi_r_ready) begin
        axi_r_valid <= 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (axi_b_ready && axi_ar_valid) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is accepted on the following posedge.
  task automatic issue(input logic wen, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s);
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
    chk("req_ready_at_issue", req_ready, 1'b1);
    $display("TB req wen=%0d addr=%h data=%h strb=%h", wen, a, d, s);
  endtask

  // lat = cycles after the accept edge at which resp_valid is seen (0 = timed out).
  task automatic wait_resp(output int lat, output logic [63:0] rd, output logic er,
                           output logic av1, output logic wv1, output logic arv1);
    lat = 0; rd = '0; er = 1'bx; av1 = 1'b0; wv1 = 1'b0; arv1 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (n == 1) begin av1 = axi_aw_valid; wv1 = axi_w_valid; arv1 = axi_ar_valid; end
      if (resp_valid) begin
        lat = n; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    $display("TB resp lat=%0d rdata=%h err=%0d", lat, rd, er);
  endtask

  int          lat, p0;
  logic [63:0] rd;
  logic        er, av1, wv1, arv1;

  initial begin
    reset = 1'b1; slave_rst = 1'b1; err_mode = 1'b0; b_stall = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    axi_aw_ready = 1'b1; axi_w_ready = 1'b1; axi_ar_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_valids", {axi_aw_valid, axi_w_valid, axi_ar_valid, axi_b_ready, axi_r_ready,
                       resp_valid, resp_err}, 7'b0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_aw_addr", axi_aw_addr, 32'd0);
    reset = 1'b0; slave_rst = 1'b0;
    @(negedge clock);

    // Basic write then back-to-back read of the same address
    issue(1'b1, 32'h8000_0000, 64'h1122334455667788, 8'hFF);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    chk("wr_aw_w_cycle1", {av1, wv1}, 2'b11);
    chk("wr_latency", lat, 3);
    chk("wr_err", er, 1'b0);
    chk("wr_rdata_zero", rd, 64'd0);
    issue(1'b0, 32'h8000_0000, 64'd0, 8'h00);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    chk("rd_ar_cycle1", arv1, 1'b1);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd, 64'h1122334455667788);
    chk("rd_err", er, 1'b0);

    // AW held off for three edges while W completes first
    @(negedge clock);
    axi_aw_ready = 1'b0;
    p0 = resp_cnt;
    issue(1'b1, 32'h8000_0010, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
    @(negedge clock);
    req_valid = 1'b0;
    chk("stall_c1_valids", {axi_aw_valid, axi_w_valid}, 2'b11);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock);
      chk("stall_aw_held_w_dropped", {axi_aw_valid, axi_w_valid, axi_b_ready}, 3'b100);
      chk("stall_aw_addr", axi_aw_addr, 32'h8000_0010);
    end
    axi_aw_ready = 1'b1;
    wait_resp(lat, rd, er, av1, wv1, arv1);
    chk("stall_resp_lat", lat, 2);
    repeat (3) @(negedge clock);
    chk("stall_one_pulse", resp_cnt - p0, 1);
    issue(1'b0, 32'h8000_0010, 64'd0, 8'h00);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    chk("stall_readback", rd, 64'hA5A5_5A5A_0F0F_F0F0);

    // Error responses on read and write
    err_mode = 1'b1;
    issue(1'b0, 32'h8000_0000, 64'd0, 8'h00);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    chk("rerr_err", er, 1'b1);
    chk("rerr_data", rd, 64'hDEAD);
    issue(1'b1, 32'h8000_0200, 64'h1234, 8'hFF);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    chk("berr_err", er, 1'b1);
    chk("berr_rdata", rd, 64'd0);
    err_mode = 1'b0;

    // Partial strobe write over zero
    issue(1'b1, 32'h8000_0100, 64'd0, 8'hFF);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    issue(1'b1, 32'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    issue(1'b0, 32'h8000_0100, 64'd0, 8'h00);
    wait_resp(lat, rd, er, av1, wv1, arv1);
    chk("strb_readback", rd, 64'h0000_0000_FFFF_FFFF);
    chk("strb_err", er, 1'b0);

    // Reset while in WRESP with B pending
    @(negedge clock);
    b_stall = 1'b1;
    p0 = resp_cnt;
    issue(1'b1, 32'h8000_0020, 64'h77, 8'hFF);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("mid_in_wresp", axi_b_ready, 1'b1);
    b_stall = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_valids", {axi_aw_valid, axi_w_valid, axi_ar_valid, axi_b_ready, axi_r_ready,
                           resp_valid, resp_err}, 7'b0);
    chk("mid_rst_rdata", resp_rdata, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_req_ready", req_ready, 1'b1);
    chk("mid_stray_b_ignored", axi_b_ready, 1'b0);
    repeat (3) @(negedge clock);
    chk("mid_no_resp", resp_cnt - p0, 0);
    $display("TB reset-abort done");
    slave_rst = 1'b1;
    @(negedge clock);
    slave_rst = 1'b0;

    chk("no_ar_b_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
AXI-Lite master bridge between the core's load/store unit and the AXI-Lite SRAM slave. It converts a single-outstanding request/response interface into AXI-Lite AR/R or AW/W/B transactions. It drives the SRAM slave's channels directly. It handles one transaction at a time, with no reordering.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  LSU request valid
req_ready  out  1  bridge can accept a request
req_wen  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  write byte mask
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  read data (0 for writes)
resp_err  out  1  slave returned non-OKAY resp
axi_aw_valid  out  1  write address valid
axi_aw_ready  in  1  write address ready
axi_aw_addr  out  ADDR_W  write address
axi_w_valid  out  1  write data valid
axi_w_ready  in  1  write data ready
axi_w_data  out  DATA_W  write data
axi_w_strb  out  DATA_W/8  write strobe
axi_b_valid  in  1  write response valid
axi_b_ready  out  1  write response ready
axi_b_resp  in  2  write response code
axi_ar_valid  out  1  read address valid
axi_ar_ready  in  1  read address ready
axi_ar_addr  out  ADDR_W  read address
axi_r_valid  in  1  read data valid
axi_r_ready  out  1  read data ready
axi_r_data  in  DATA_W  read data
axi_r_resp  in  2  read response code
The prot signals are tied to 3'b000 at the top level and are not ports of this block.

Behaviour:
- Reset (async, immediate): state=IDLE; all AXI valid/ready outputs 0; resp_valid=0, resp_err=0, resp_rdata=0; address/data registers cleared.
- req_ready = (state==IDLE). It is 1 out of reset.
- A request is accepted on req_valid&&req_ready. Address, data and strobe are registered. Registered AXI address/data outputs hold stable until their handshake.
- States: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE + accept, wen=1 → WADDR.
  - Next cycle: aw_valid=1 and w_valid=1 together.
  - Each valid drops independently in the cycle after its own handshake. Internal aw_done/w_done flags track completion.
  - AW and W may complete in either order or in the same cycle.
  - valid is never withdrawn before handshake.
- WADDR → WRESP when both are done. This can happen in the same cycle as the last handshake.
  - b_ready=1 throughout WRESP; b_ready is 0 in all other states.
  - On b_valid&&b_ready: next cycle resp_valid=1, resp_err=(b_resp!=0), resp_rdata=0, state=IDLE.
- IDLE + accept, wen=0 → RADDR.
  - ar_valid=1 until the ar handshake, then → RDATA.
  - r_ready=1 only in RDATA.
  - On r_valid&&r_ready: next cycle resp_valid=1, resp_rdata=r_data, resp_err=(r_resp!=0), state=IDLE.
- resp_valid is a single-cycle pulse with no backpressure; the LSU must sample it.
- req_ready is 1 in the same cycle as resp_valid, so back-to-back requests are allowed.
- Stray b_valid/r_valid outside WRESP/RDATA is ignored, because the ready signals are 0.
- Latency against the SRAM slave (ready-high slave, response one cycle after handshake):
  - Write: accept@0, AW/W handshake@1, B handshake@2, resp_valid@3.
  - Read: accept@0, AR handshake@1, R handshake@2, resp_valid@3.
- Reset asserted mid-transaction aborts immediately to IDLE with all valids 0. No response is generated.

Test Plan:
- Write addr 0x8000_0000, data 0x1122334455667788, strb 0xFF against SRAM model → aw/w valid cycle 1, resp_valid cycle 3, resp_err=0. A following read of the same address returns 0x1122334455667788 at cycle 3 after its accept.
- Slave holds aw_ready low 3 cycles while w_ready=1 → W completes first, w_valid drops, aw_valid held with a stable address, B is accepted only after AW completes, exactly one resp_valid pulse.
- Back-to-back: read issued in the same cycle as the previous write's resp_valid → accepted with no bubble; no overlap of AR and B phases.
- Slave returns r_resp=2'b10 with data 0xDEAD → resp_valid with resp_err=1 and resp_rdata=0xDEAD. b_resp=2'b10 → resp_err=1 and resp_rdata=0.
- Strobe 0x0F write of 0xFFFFFFFF_FFFFFFFF over 0 → read-back 0x00000000_FFFFFFFF.
- Reset asserted while in WRESP with b_valid pending → outputs 0 immediately, req_ready=1 after deassert, no resp_valid emitted.
